// File: rtl/dmg_clkgen.sv
// Oscillator warm-up, T-state phase and synchronous-reset generator for the CPU sequencer.
// Outputs are registered on CLK; STOP and HALT take effect only at machine-cycle boundaries.
module dmg_clkgen #(
    parameter int STABLE_CYCLES = 16,
    parameter int RESET_HOLD    = 4
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       OSC_ENA,
    input  logic       CLK_ENA,
    output logic       OSC_STABLE,
    output logic       SYNC_RESET,
    output logic [1:0] PHASE,
    output logic       M_START,
    output logic       CPU_CE,
    output logic [3:0] CE_PH
);

    localparam int WW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state;
    logic [WW-1:0]   warm_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            clk_ena_q;

    // clk_ena_q is only ever set while in RUN, so it doubles as the core clock enable.
    assign CPU_CE = clk_ena_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= ST_WARMUP;
            warm_cnt   <= '0;
            hold_cnt   <= '0;
            clk_ena_q  <= 1'b0;
            OSC_STABLE <= 1'b0;
            SYNC_RESET <= 1'b1;
            PHASE      <= 2'd0;
            M_START    <= 1'b0;
            CE_PH      <= 4'b0000;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (!OSC_ENA) begin
                        state    <= ST_OFF;
                        warm_cnt <= '0;
                    end else if (warm_cnt == WW'(STABLE_CYCLES - 1)) begin
                        state      <= ST_RUN;
                        warm_cnt   <= WW'(STABLE_CYCLES);
                        OSC_STABLE <= 1'b1;
                        PHASE      <= 2'd0;
                        M_START    <= 1'b1;
                        clk_ena_q  <= CLK_ENA;
                        CE_PH      <= {3'b000, CLK_ENA};
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (PHASE == 2'd3) begin
                        if (!OSC_ENA) begin
                            // STOP wins over the CLK_ENA resample on the same boundary.
                            state      <= ST_OFF;
                            warm_cnt   <= '0;
                            OSC_STABLE <= 1'b0;
                            PHASE      <= 2'd0;
                            M_START    <= 1'b0;
                            clk_ena_q  <= 1'b0;
                            CE_PH      <= 4'b0000;
                            if (SYNC_RESET)
                                hold_cnt <= '0;
                        end else begin
                            PHASE     <= 2'd0;
                            M_START   <= 1'b1;
                            clk_ena_q <= CLK_ENA;
                            CE_PH     <= {3'b000, CLK_ENA};
                            // Counter freezes once reset is released, giving saturation.
                            if (SYNC_RESET) begin
                                hold_cnt <= hold_cnt + 1'b1;
                                if (hold_cnt == HW'(RESET_HOLD - 1))
                                    SYNC_RESET <= 1'b0;
                            end
                        end
                    end else begin
                        PHASE   <= PHASE + 2'd1;
                        M_START <= 1'b0;
                        CE_PH   <= clk_ena_q ? (4'b0001 << (PHASE + 2'd1)) : 4'b0000;
                    end
                end

                ST_OFF: begin
                    if (OSC_ENA)
                        state <= ST_WARMUP;
                end

                default: begin
                    state    <= ST_WARMUP;
                    warm_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmg_clkgen.sv
// Directed bench for dmg_clkgen with default parameters (16-cycle warm-up, 4-cycle reset hold).
module tb_dmg_clkgen;

    logic       CLK;
    logic       nRESET;
    logic       OSC_ENA;
    logic       CLK_ENA;
    logic       OSC_STABLE;
    logic       SYNC_RESET;
    logic [1:0] PHASE;
    logic       M_START;
    logic       CPU_CE;
    logic [3:0] CE_PH;

    int total = 0;
    int bad   = 0;

    dmg_clkgen #(.STABLE_CYCLES(16), .RESET_HOLD(4)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .OSC_ENA    (OSC_ENA),
        .CLK_ENA    (CLK_ENA),
        .OSC_STABLE (OSC_STABLE),
        .SYNC_RESET (SYNC_RESET),
        .PHASE      (PHASE),
        .M_START    (M_START),
        .CPU_CE     (CPU_CE),
        .CE_PH      (CE_PH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [9:0] obs;
    assign obs = {OSC_STABLE, SYNC_RESET, PHASE, M_START, CPU_CE, CE_PH};

    function automatic logic [9:0] pk(input logic os, input logic sr, input logic [1:0] ph,
                                      input logic ms, input logic ce, input logic [3:0] ceph);
        return {os, sr, ph, ms, ce, ceph};
    endfunction

    task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed={stb,srst,ph,ms,ce,ceph}=%b expected=%b", tag, o, e);
        end
    endtask

    // Advance n rising edges and settle 2ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    initial begin
        nRESET  = 1'b0;
        OSC_ENA = 1'b1;
        CLK_ENA = 1'b1;
        #12;
        chk("reset_values", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));

        // Power-up: edge 1 is the first rising edge after release.
        @(negedge CLK);
        nRESET = 1'b1;
        step(15);
        chk("warmup_edge15", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));
        step(1);
        chk("run_entry_edge16", obs, pk(1, 1, 2'd0, 1, 1, 4'b0001));
        step(1);
        chk("phase1", obs, pk(1, 1, 2'd1, 0, 1, 4'b0010));
        step(1);
        chk("phase2", obs, pk(1, 1, 2'd2, 0, 1, 4'b0100));
        step(1);
        chk("phase3", obs, pk(1, 1, 2'd3, 0, 1, 4'b1000));
        step(1);
        chk("phase0_wrap_edge20", obs, pk(1, 1, 2'd0, 1, 1, 4'b0001));
        step(11);
        chk("srst_held_edge31", obs, pk(1, 1, 2'd3, 0, 1, 4'b1000));
        step(1);
        chk("srst_release_edge32", obs, pk(1, 0, 2'd0, 1, 1, 4'b0001));

        // HALT: drop CLK_ENA at PHASE 1, restore at PHASE 2.
        step(1);
        CLK_ENA = 1'b0;
        step(1);
        chk("halt_req_ph2", obs, pk(1, 0, 2'd2, 0, 1, 4'b0100));
        step(1);
        chk("halt_req_ph3", obs, pk(1, 0, 2'd3, 0, 1, 4'b1000));
        step(1);
        chk("halt_ph0", obs, pk(1, 0, 2'd0, 1, 0, 4'b0000));
        step(1);
        chk("halt_ph1", obs, pk(1, 0, 2'd1, 0, 0, 4'b0000));
        step(1);
        CLK_ENA = 1'b1;
        chk("halt_ph2", obs, pk(1, 0, 2'd2, 0, 0, 4'b0000));
        step(1);
        chk("halt_exit_ph3", obs, pk(1, 0, 2'd3, 0, 0, 4'b0000));
        step(1);
        chk("halt_exit_ph0", obs, pk(1, 0, 2'd0, 1, 1, 4'b0001));

        // STOP mid-cycle: drop OSC_ENA at PHASE 1, cycle completes, then OFF.
        step(1);
        OSC_ENA = 1'b0;
        step(1);
        chk("stop_ph2", obs, pk(1, 0, 2'd2, 0, 1, 4'b0100));
        step(1);
        chk("stop_ph3", obs, pk(1, 0, 2'd3, 0, 1, 4'b1000));
        step(1);
        chk("stop_off", obs, pk(0, 0, 2'd0, 0, 0, 4'b0000));
        step(1);
        chk("stop_off_hold", obs, pk(0, 0, 2'd0, 0, 0, 4'b0000));
        OSC_ENA = 1'b1;
        step(16);
        chk("rewarm_not_ready", obs, pk(0, 0, 2'd0, 0, 0, 4'b0000));
        step(1);
        chk("rewarm_run", obs, pk(1, 0, 2'd0, 1, 1, 4'b0001));

        // Asynchronous reset at PHASE 2, checked before any further edge.
        step(2);
        chk("pre_areset_ph2", obs, pk(1, 0, 2'd2, 0, 1, 4'b0100));
        #1;
        nRESET = 1'b0;
        #1;
        chk("async_reset", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));

        // Warm-up abort after edge 10; restart needs a full warm-up.
        @(negedge CLK);
        nRESET = 1'b1;
        step(10);
        OSC_ENA = 1'b0;
        step(1);
        chk("abort_off", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));
        OSC_ENA = 1'b1;
        step(1);
        step(15);
        chk("abort_rewarm_15", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));
        step(1);
        chk("abort_rewarm_run", obs, pk(1, 1, 2'd0, 1, 1, 4'b0001));

        // STOP during the 2nd machine cycle before the hold completes.
        step(5);
        OSC_ENA = 1'b0;
        chk("early_stop_ph1", obs, pk(1, 1, 2'd1, 0, 1, 4'b0010));
        step(3);
        chk("early_stop_off", obs, pk(0, 1, 2'd0, 0, 0, 4'b0000));
        OSC_ENA = 1'b1;
        step(17);
        chk("early_stop_rerun", obs, pk(1, 1, 2'd0, 1, 1, 4'b0001));
        step(15);
        chk("hold_restart_held", obs, pk(1, 1, 2'd3, 0, 1, 4'b1000));
        step(1);
        chk("hold_restart_release", obs, pk(1, 0, 2'd0, 1, 1, 4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
